// File: rtl/parallel_to_series.sv
// -----------------------------------------------------------------------------
// parallel_to_series
//   Transmit-side serializer for the FSK link. A WIDTH-bit word is accepted
//   through a valid/ready handshake and sent on sig_ser LSB first, one bit per
//   BIT_CYCLES clocks. This way the receive-side shift-in register rebuilds
//   the word with its original bit order.
//
// Ports
//   clk_16      in   system clock; all logic on the rising edge
//   reset       in   synchronous, active-high reset
//   sig_par     in   [WIDTH] word to send; sampled only on accept
//   load_valid  in   sig_par holds a word to send
//   load_ready  out  block can accept a word this cycle (combinational)
//   sig_ser     out  serial bit stream, registered; IDLE_LEVEL when idle
//   bit_strobe  out  registered pulse in the last cycle of every bit period
//   frame_done  out  registered pulse on the bit_strobe of the final bit
//   busy        out  high while a frame is being shifted
// -----------------------------------------------------------------------------
module parallel_to_series #(
   parameter int   WIDTH      = 16,
   parameter int   BIT_CYCLES = 1,
   parameter logic IDLE_LEVEL = 1'b0
) (
   input  logic             clk_16,
   input  logic             reset,
   input  logic [WIDTH-1:0] sig_par,
   input  logic             load_valid,
   output logic             load_ready,
   output logic             sig_ser,
   output logic             bit_strobe,
   output logic             frame_done,
   output logic             busy
);

   localparam int IDX_W = $clog2(WIDTH);
   // With BIT_CYCLES == 1 the divider is kept one bit wide and stays at zero.
   localparam int DIV_W = (BIT_CYCLES > 1) ? $clog2(BIT_CYCLES) : 1;

   localparam logic [0:0] ST_IDLE  = 1'b0;
   localparam logic [0:0] ST_SHIFT = 1'b1;

   localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(WIDTH - 1);
   localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(BIT_CYCLES - 1);

   logic [0:0]       state,   state_n;
   logic [WIDTH-1:0] shreg,   shreg_n;
   logic [IDX_W-1:0] bit_idx, bit_idx_n;
   logic [DIV_W-1:0] div,     div_n;
   logic             sig_ser_n;
   logic             strobe_n;
   logic             done_n;

   logic bit_end;
   logic last_cycle;
   logic accept;

   assign bit_end    = (state == ST_SHIFT) && (div == DIV_LAST);
   assign last_cycle = bit_end && (bit_idx == IDX_LAST);
   // Accepting in the last cycle of a frame lets the next frame follow with no idle gap.
   assign load_ready = !reset && ((state == ST_IDLE) || last_cycle);
   assign accept     = load_valid && load_ready;

   always_comb begin
      // NOTE: every signal gets a hold value first so no path leaves one
      // unassigned; that is what keeps this block from inferring latches.
      state_n   = state;
      shreg_n   = shreg;
      bit_idx_n = bit_idx;
      div_n     = div;
      sig_ser_n = sig_ser;

      if (accept) begin
         state_n   = ST_SHIFT;
         shreg_n   = sig_par;
         bit_idx_n = '0;
         div_n     = '0;
         sig_ser_n = sig_par[0];
      end else if (state == ST_SHIFT) begin
         if (last_cycle) begin
            state_n   = ST_IDLE;
            bit_idx_n = '0;
            div_n     = '0;
            sig_ser_n = IDLE_LEVEL;
         end else if (bit_end) begin
            // The word shifts right so the next bit to send always sits in shreg[1].
            div_n     = '0;
            bit_idx_n = bit_idx + 1'b1;
            shreg_n   = shreg >> 1;
            sig_ser_n = shreg[1];
         end else begin
            div_n = div + 1'b1;
         end
      end

      // The strobes are registered, so they are computed from the next-state
      // values. That makes them line up with the cycle they describe.
      strobe_n = (state_n == ST_SHIFT) && (div_n == DIV_LAST);
      done_n   = strobe_n && (bit_idx_n == IDX_LAST);
   end

   always_ff @(posedge clk_16) begin
      // NOTE: sequential state uses non-blocking assignments, so every flop
      // samples values from before the edge, whatever the statement order.
      if (reset) begin
         state      <= ST_IDLE;
         shreg      <= '0;
         bit_idx    <= '0;
         div        <= '0;
         sig_ser    <= IDLE_LEVEL;
         bit_strobe <= 1'b0;
         frame_done <= 1'b0;
         busy       <= 1'b0;
      end else begin
         state      <= state_n;
         shreg      <= shreg_n;
         bit_idx    <= bit_idx_n;
         div        <= div_n;
         sig_ser    <= sig_ser_n;
         bit_strobe <= strobe_n;
         frame_done <= done_n;
         busy       <= (state_n == ST_SHIFT);
      end
   end

endmodule

// File: tb/tb_parallel_to_series.sv
// -----------------------------------------------------------------------------
// tb_parallel_to_series
//   Self-checking bench for parallel_to_series. dut1 runs with BIT_CYCLES=1
//   and covers reset, the single frame, back-to-back frames, mid-frame reset
//   and the busy-ignore cases. dut4 runs with BIT_CYCLES=4 and drives a
//   loopback receive shift chain.
// -----------------------------------------------------------------------------
module tb_parallel_to_series;

   logic        clk_16 = 1'b0;
   logic        reset;

   logic [15:0] par1, par4;
   logic        lv1, lv4;
   logic        ready1, ser1, bs1, fd1, busy1;
   logic        ready4, ser4, bs4, fd4, busy4;

   int checks   = 0;
   int failures = 0;

   always #5 clk_16 = ~clk_16;

   parallel_to_series #(.WIDTH(16), .BIT_CYCLES(1), .IDLE_LEVEL(1'b0)) dut1 (
      .clk_16    (clk_16),
      .reset     (reset),
      .sig_par   (par1),
      .load_valid(lv1),
      .load_ready(ready1),
      .sig_ser   (ser1),
      .bit_strobe(bs1),
      .frame_done(fd1),
      .busy      (busy1)
   );

   parallel_to_series #(.WIDTH(16), .BIT_CYCLES(4), .IDLE_LEVEL(1'b0)) dut4 (
      .clk_16    (clk_16),
      .reset     (reset),
      .sig_par   (par4),
      .load_valid(lv4),
      .load_ready(ready4),
      .sig_ser   (ser4),
      .bit_strobe(bs4),
      .frame_done(fd4),
      .busy      (busy4)
   );

   // Receive-side model: a shift-in chain enabled by bit_strobe. Its output
   // register is loaded when frame_done, delayed one clock, is high.
   logic [15:0] rx_shift, sig_use;
   logic        fd4_d, use_valid;

   always @(posedge clk_16) begin
      if (reset) begin
         rx_shift  <= '0;
         sig_use   <= '0;
         fd4_d     <= 1'b0;
         use_valid <= 1'b0;
      end else begin
         if (bs4) rx_shift <= {ser4, rx_shift[15:1]};
         fd4_d <= fd4;
         if (fd4_d) begin
            sig_use   <= rx_shift;
            use_valid <= 1'b1;
         end
      end
   end

   typedef struct {
      logic        lv;
      logic [15:0] par;
      logic        ser;
      logic        strobe;
      logic        done;
      logic        busy;
      logic        ready;
   } vec_t;

   vec_t tbl[17];

   task automatic tick();
      @(posedge clk_16);
      #1;
   endtask

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Starts in bit 0 of a dut1 frame and ends one cycle after its last bit.
   // Optionally raises load_valid with 16'h00FF during bit inject_at.
   task automatic recv16(input int inject_at, output logic [15:0] word,
                         output int ndone, output logic done_last);
      ndone     = 0;
      done_last = 1'b0;
      for (int j = 0; j < 16; j++) begin
         word[j] = ser1;
         if (fd1) ndone++;
         if (j == 15) done_last = fd1;
         if (j == inject_at) begin
            lv1  = 1'b1;
            par1 = 16'h00FF;
         end else begin
            lv1 = 1'b0;
         end
         tick();
      end
      lv1 = 1'b0;
   endtask

   logic exp_bits[16] = '{1,1,0,0,0,0,1,1,1,0,1,0,0,1,0,1};

   initial begin
      logic [15:0] word;
      int          ndone;
      logic        done_last;
      int          nstrobe, nbusy, phase_err, cyc, bad;

      reset = 1'b1;
      lv1 = 1'b0; par1 = '0;
      lv4 = 1'b0; par4 = '0;

      // ---- 1: reset holds the block idle even with load_valid high
      lv1 = 1'b1;
      par1 = 16'hFFFF;
      for (int i = 0; i < 3; i++) begin
         tick();
         check("rst_ready", ready1, 0);
         check("rst_ser", ser1, 0);
         check("rst_busy", busy1, 0);
      end
      check("rst_strobe", bs1, 0);
      lv1 = 1'b0;
      reset = 1'b0;
      tick();
      check("post_rst_ready", ready1, 1);
      check("post_rst_ready4", ready4, 1);

      // ---- 2: single frame 16'hA5C3, table driven
      for (int i = 0; i < 16; i++)
         tbl[i] = '{lv: (i == 0), par: 16'hA5C3, ser: exp_bits[i], strobe: 1'b1,
                    done: (i == 15), busy: 1'b1, ready: (i == 15)};
      tbl[16] = '{lv: 1'b0, par: 16'h0000, ser: 1'b0, strobe: 1'b0,
                  done: 1'b0, busy: 1'b0, ready: 1'b1};
      for (int i = 0; i < 17; i++) begin
         lv1  = tbl[i].lv;
         par1 = tbl[i].par;
         tick();
         check($sformatf("frame_ser[%0d]", i), ser1, tbl[i].ser);
         check($sformatf("frame_strobe[%0d]", i), bs1, tbl[i].strobe);
         check($sformatf("frame_done[%0d]", i), fd1, tbl[i].done);
         check($sformatf("frame_busy[%0d]", i), busy1, tbl[i].busy);
         check($sformatf("frame_ready[%0d]", i), ready1, tbl[i].ready);
      end
      lv1 = 1'b0;

      // ---- 3: loopback at BIT_CYCLES=4 into the receive shift chain
      lv4  = 1'b1;
      par4 = 16'h1234;
      tick();
      lv4 = 1'b0;
      nstrobe = 0; nbusy = 0; phase_err = 0; cyc = 0;
      while (!use_valid && cyc < 100) begin
         if (bs4) begin
            nstrobe++;
            if (cyc % 4 != 3) phase_err++;
         end
         if (busy4) nbusy++;
         cyc++;
         tick();
      end
      check("loop_timeout", use_valid, 1);
      check("loop_sig_use", sig_use, 16'h1234);
      check("loop_strobes", nstrobe, 16);
      check("loop_busy_cycles", nbusy, 64);
      check("loop_strobe_phase", phase_err, 0);

      // ---- 4: back-to-back frames with load_valid held high
      lv1  = 1'b1;
      par1 = 16'hFFFF;
      tick();
      bad = 0;
      for (int j = 0; j < 32; j++) begin
         if (ser1 !== (j < 16))                  bad++;
         if (busy1 !== 1'b1)                     bad++;
         if (ready1 !== (j == 15 || j == 31))    bad++;
         if (fd1 !== (j == 15 || j == 31))       bad++;
         if (j == 15) par1 = 16'h0000;
         if (j == 31) lv1 = 1'b0;
         tick();
      end
      check("b2b_errors", bad, 0);
      check("b2b_end_busy", busy1, 0);
      check("b2b_end_ready", ready1, 1);

      // ---- 5: reset during bit 7 aborts the frame
      lv1  = 1'b1;
      par1 = 16'hFFFF;
      tick();
      lv1 = 1'b0;
      for (int j = 0; j < 7; j++) tick();
      check("pre_abort_ser", ser1, 1);
      reset = 1'b1;
      tick();
      reset = 1'b0;
      check("abort_ser", ser1, 0);
      check("abort_busy", busy1, 0);
      check("abort_done", fd1, 0);
      bad = 0;
      for (int j = 0; j < 4; j++) begin
         tick();
         if (fd1 !== 1'b0 || busy1 !== 1'b0 || ser1 !== 1'b0) bad++;
      end
      check("abort_quiet", bad, 0);
      lv1  = 1'b1;
      par1 = 16'hFFFF;
      tick();
      lv1 = 1'b0;
      recv16(-1, word, ndone, done_last);
      check("after_abort_word", word, 16'hFFFF);
      check("after_abort_done_last", done_last, 1);
      check("after_abort_ndone", ndone, 1);
      check("after_abort_idle", busy1, 0);

      // ---- 6: load_valid during bit 5 is ignored
      lv1  = 1'b1;
      par1 = 16'h0F0F;
      tick();
      lv1 = 1'b0;
      recv16(5, word, ndone, done_last);
      check("ignore_word", word, 16'h0F0F);
      check("ignore_ndone", ndone, 1);
      check("ignore_idle_busy", busy1, 0);
      check("ignore_idle_ser", ser1, 0);
      tick();
      check("ignore_still_idle", busy1, 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
